// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with write-to-read bypass and pending-write scoreboard.
// Define REG_ZERO_HARDWIRED_EN to make register 0 a constant zero (MIPS $zero style).
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rsv_en,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  rd_busy_a,
    output logic                  rd_busy_b,
    output logic [ADDR_WIDTH:0]   busy_count
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_nxt;
    logic                  wr_eff;
    logic                  rsv_eff;
    logic                  cnt_inc;
    logic                  cnt_dec;
    logic                  byp_a;
    logic                  byp_b;

`ifdef REG_ZERO_HARDWIRED_EN
    assign wr_eff  = wr_en  && (wr_addr  != '0);
    assign rsv_eff = rsv_en && (rsv_addr != '0);
`else
    assign wr_eff  = wr_en;
    assign rsv_eff = rsv_en;
`endif

    // Reserve is applied after the write clear: a newer producer wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_eff)
            busy_nxt[wr_addr] = 1'b0;
        if (rsv_eff)
            busy_nxt[rsv_addr] = 1'b1;
    end

    // Only the reserved bit can rise and only the written bit can fall.
    assign cnt_inc = rsv_eff && !busy[rsv_addr];
    assign cnt_dec = wr_eff && busy[wr_addr]
                   && !(rsv_eff && (rsv_addr == wr_addr));

    assign byp_a = wr_eff && (wr_addr == rd_addr_a);
    assign byp_b = wr_eff && (wr_addr == rd_addr_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_eff) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= busy_count
                        + (ADDR_WIDTH+1)'(cnt_inc)
                        - (ADDR_WIDTH+1)'(cnt_dec);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
            rd_busy_a <= 1'b0;
            rd_busy_b <= 1'b0;
        end else begin
            rd_data_a <= byp_a ? wr_data : regs[rd_addr_a];
            rd_data_b <= byp_b ? wr_data : regs[rd_addr_b];
            rd_busy_a <= busy_nxt[rd_addr_a];
            rd_busy_b <= busy_nxt[rd_addr_b];
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: stimulus queues expected read results,
// a negedge monitor pops and compares them one cycle after each checked edge.
module tb_regfile_scoreboard;

    localparam int NR = 16;
`ifdef REG_ZERO_HARDWIRED_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif
    localparam int NRES = NR - FIRST;

    typedef struct {
        logic [31:0] da;
        logic [31:0] db;
        logic        ba;
        logic        bb;
        logic [4:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rsv_en = 1'b0;
    logic [3:0]  rsv_addr = '0;
    logic [3:0]  rd_addr_a = '0;
    logic [3:0]  rd_addr_b = '0;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        rd_busy_a;
    logic        rd_busy_b;
    logic [4:0]  busy_count;

    logic        chk_d = 1'b0;
    logic        chk_q;
    exp_t        exp_q[$];
    string       nm_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rsv_en(rsv_en),
        .rsv_addr(rsv_addr),
        .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b),
        .rd_busy_a(rd_busy_a),
        .rd_busy_b(rd_busy_b),
        .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst)
            chk_q <= 1'b0;
        else
            chk_q <= chk_d;
    end

    task automatic check(input string nm, input string fld,
                         input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s %s: got %h expected %h", nm, fld, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (chk_q) begin
            if (exp_q.size() == 0) begin
                check("monitor", "queue_underflow", 32'd1, 32'd0);
            end else begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = nm_q.pop_front();
                check(nm, "rd_data_a", rd_data_a, e.da);
                check(nm, "rd_data_b", rd_data_b, e.db);
                check(nm, "rd_busy_a", {31'd0, rd_busy_a}, {31'd0, e.ba});
                check(nm, "rd_busy_b", {31'd0, rd_busy_b}, {31'd0, e.bb});
                check(nm, "busy_count", {27'd0, busy_count}, {27'd0, e.cnt});
            end
        end
    end

    task automatic cyc(input logic we, input logic [3:0] wa,
                       input logic [31:0] wd, input logic re,
                       input logic [3:0] sa, input logic [3:0] ra,
                       input logic [3:0] rb, input logic c,
                       input logic [31:0] eda, input logic [31:0] edb,
                       input logic eba, input logic ebb,
                       input logic [4:0] ecnt, input string nm);
        exp_t e;
        @(negedge clk);
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rsv_en    = re;
        rsv_addr  = sa;
        rd_addr_a = ra;
        rd_addr_b = rb;
        chk_d     = c;
        if (c) begin
            e = '{eda, edb, eba, ebb, ecnt};
            exp_q.push_back(e);
            nm_q.push_back(nm);
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
    endtask

    task automatic check_zero(input string nm);
        check(nm, "rd_data_a", rd_data_a, 32'd0);
        check(nm, "rd_data_b", rd_data_b, 32'd0);
        check(nm, "rd_busy_a", {31'd0, rd_busy_a}, 32'd0);
        check(nm, "rd_busy_b", {31'd0, rd_busy_b}, 32'd0);
        check(nm, "busy_count", {27'd0, busy_count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst = 1'b1;
        #1 check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Write r3, then a pending write is aborted by a mid-cycle reset.
        cyc(1, 3, 32'hDEADBEEF, 0, 0, 3, 3, 1,
            32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, "wr_r3");
        cyc(0, 0, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, "hold");
        cyc(1, 3, 32'hCAFEF00D, 1, 3, 3, 3, 0, 0, 0, 0, 0, 0, "abort");
        #2 rst = 1'b1;
        #1 check_zero("rst_async");
        @(negedge clk);
        rst = 1'b0;
        wr_en = 1'b0;
        rsv_en = 1'b0;
        cyc(0, 0, 0, 0, 0, 3, 3, 1, 0, 0, 0, 0, 0, "r3_after_rst");

        cyc(1, 5, 32'h12345678, 0, 0, 5, 5, 1,
            32'h12345678, 32'h12345678, 0, 0, 0, "bypass");
        cyc(0, 0, 0, 1, 7, 7, 5, 1, 0, 32'h12345678, 1, 0, 1, "rsv_r7");
        cyc(1, 7, 32'hA5, 0, 0, 7, 7, 1, 32'hA5, 32'hA5, 0, 0, 0, "wr_r7");

        cyc(0, 0, 0, 1, 9, 9, 9, 1, 0, 0, 1, 1, 1, "rsv_r9");
        cyc(1, 9, 32'h55, 1, 9, 9, 9, 1, 32'h55, 32'h55, 1, 1, 1,
            "conflict_busy");
        cyc(1, 9, 32'h0, 0, 0, 9, 9, 1, 0, 0, 0, 0, 0, "clr_r9");
        cyc(1, 9, 32'h66, 1, 9, 9, 7, 1, 32'h66, 32'hA5, 1, 0, 1,
            "conflict_idle");
        cyc(1, 9, 32'h0, 0, 0, 9, 9, 1, 0, 0, 0, 0, 0, "clr_r9b");
        cyc(1, 4, 32'h44, 1, 2, 2, 4, 1, 0, 32'h44, 1, 0, 1, "rsv_wr_diff");
        cyc(1, 2, 32'h22, 0, 0, 2, 4, 1, 32'h22, 32'h44, 0, 0, 0, "clr_r2");

        // Fresh state for the count-bounds sweep.
        idle();
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        for (int i = FIRST; i < NR; i++)
            cyc(0, 0, 0, 1, i[3:0], i[3:0], i[3:0], 1,
                0, 0, 1, 1, 5'(i - FIRST + 1), "rsv_all");
        cyc(0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 1, 1, 5'(NRES), "rsv_again");
        for (int i = FIRST; i < NR; i++)
            cyc(1, i[3:0], 32'h100 + 32'(i), 0, 0, i[3:0], 1, 1,
                32'h100 + 32'(i), (i >= 1) ? 32'h101 : 32'h0,
                0, (i < 1), 5'(NRES - (i - FIRST + 1)), "wr_all");
        cyc(1, 6, 32'h77, 0, 0, 6, 6, 1, 32'h77, 32'h77, 0, 0, 0, "wr_idle");

`ifdef REG_ZERO_HARDWIRED_EN
        cyc(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "zero_reg");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "zero_hold");
`else
        cyc(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 1,
            32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 1, "zero_reg");
        cyc(0, 0, 0, 0, 0, 0, 0, 1,
            32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 1, "zero_hold");
`endif

        idle();
        repeat (3) @(negedge clk);
        check("drain", "queue_left", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file with two registered read ports, one write port, write-to-read bypass, and a per-register scoreboard of pending writes. It sits between instruction decode and write-back in the MIPS CPU datapath. Decode reserves a destination register at issue, and write-back clears the reservation. Read ports return both data and a busy flag so the hazard logic can stall.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits (true width, not MSB index)
- ADDR_WIDTH, 4, register address width; NUM_REGS = 2**ADDR_WIDTH (derived localparam)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_WIDTH  write register index
- wr_data  in  DATA_WIDTH  write data
- rsv_en  in  1  reserve strobe (mark register pending)
- rsv_addr  in  ADDR_WIDTH  register index to reserve
- rd_addr_a  in  ADDR_WIDTH  read port A index
- rd_addr_b  in  ADDR_WIDTH  read port B index
- rd_data_a  out  DATA_WIDTH  registered read data, port A
- rd_data_b  out  DATA_WIDTH  registered read data, port B
- rd_busy_a  out  1  registered busy flag of rd_addr_a
- rd_busy_b  out  1  registered busy flag of rd_addr_b
- busy_count  out  ADDR_WIDTH+1  number of currently reserved registers

## Operation
- Storage: NUM_REGS × DATA_WIDTH registers plus NUM_REGS busy bits.
- Write: on a rising edge with wr_en=1, regs[wr_addr] <= wr_data, and busy[wr_addr] is cleared.
- Reserve: on a rising edge with rsv_en=1, busy[rsv_addr] is set.
- Write and reserve in the same cycle to the same address:
  - Data is written.
  - busy stays/becomes 1, because the reserve belongs to a newer producer.
- Write and reserve to different addresses: both take effect independently.
- Reads: each rising edge samples rd_addr_x.
  - rd_data_x is set to the post-edge register content.
  - rd_busy_x is set to the post-edge busy bit.
  - Bypass: if wr_en=1 and wr_addr==rd_addr_x on that edge, rd_data_x = wr_data.
  - Busy bypass follows the same post-edge rule, including the same-address reserve-wins case.
- Both read ports may address the same register; they return identical results.
- busy_count: registered population count of the busy bits after the edge's updates.
  - Implemented as an incremental counter: +1 on a 0→1 transition, −1 on a 1→0 transition, net 0 when both occur on the same edge.
  - Range 0..NUM_REGS. It never wraps because transitions are tracked per bit.
- Reserving an already-busy register: no change, and the count does not increment.
- Writing a register that is not busy: data updates, and the count does not decrement.

## Timing
- Reset (asynchronous, with rst high): all registers, busy bits, rd_data_a/b, rd_busy_a/b and busy_count are 0 immediately.
- Release of rst is synchronised by the system. First updates occur on the first rising edge with rst low.
- Read latency: 1 cycle. The address presented in cycle N gives data/busy valid after edge N and holds until edge N+1.
- Write-to-read latency: 0 extra cycles, via the bypass.
- Reserve-to-busy visibility: same edge, via the busy bypass.
- Reset asserted mid-operation aborts all pending writes and reservations. No outputs glitch to non-zero values while rst=1.

## Configuration
- REG_ZERO_HARDWIRED_EN: defined means register 0 is a constant zero, MIPS $zero style.
  - Writes to address 0 are ignored.
  - Reserves to address 0 are ignored, so busy[0] stays 0 and busy_count is unaffected.
  - Reads of address 0 always return data 0 and busy 0, and the bypass is suppressed for address 0.
- Undefined: register 0 behaves like every other register.

## Test plan
- Reset: write 0xDEADBEEF to r3, assert rst mid-cycle → all outputs 0 immediately; after release, reading r3 returns 0 and busy_count=0.
- Bypass: wr_en=1, wr_addr=5, wr_data=0x12345678 and rd_addr_a=rd_addr_b=5 on the same edge → both rd_data=0x12345678 after that edge.
- Scoreboard: reserve r7 → rd_busy_a(r7)=1 and busy_count=1; write r7=0xA5 → busy 0, count 0, data 0xA5.
- Same-edge conflict: reserve r9 and write r9=0x55 on one edge with r9 previously busy → data 0x55, busy stays 1, count unchanged. With r9 previously idle, the same stimulus gives busy 1 and count +1.
- Count bounds: reserve all NUM_REGS registers (NUM_REGS−1 if REG_ZERO_HARDWIRED_EN), re-reserve r1 → count saturates at exactly that value; write all → count returns to 0; write an idle register → count stays 0.
- Zero register: with REG_ZERO_HARDWIRED_EN, write 0xFFFFFFFF and reserve r0 → rd_data 0, busy 0, count 0. Without the macro → rd_data 0xFFFFFFFF, busy 1.
